// File: rtl/diff_mod_operator.sv
// diff_mod_operator
// Front stage of the unlimited-sampling recovery chain. Each accepted folded
// sample is run through ORDER finite-difference steps (one per cycle), then
// folded back into [-lambda, lambda) by repeated add/subtract of 2*lambda.
// The result is presented on y with a one-cycle y_valid pulse that drives the
// downstream anti-difference operator. The first ORDER samples after reset
// only prime the difference history and produce no y_valid.
module diff_mod_operator #(
    parameter int IN_RES     = 12,
    parameter int OUT_RES    = 16,
    parameter int ORDER      = 2,
    parameter int ORDER_BITS = 2,
    parameter int MAX_FOLD   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [IN_RES-1:0]  x,
    input  logic        [OUT_RES-1:0] lambda,
    output logic signed [OUT_RES-1:0] y,
    output logic                      y_valid,
    output logic                      busy,
    output logic                      fold_err,
    output logic                      overrun
);

    // Accumulator is wide enough that ORDER differences of a sign-extended
    // sample, and one fold step beyond, can never overflow.
    localparam int ACC_W     = OUT_RES + ORDER + 1;
    localparam int FOLD_BITS = $clog2(MAX_FOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_FOLD = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                     state_q,    state_d;
    logic signed [ACC_W-1:0]    v_q,        v_d;
    logic        [OUT_RES-1:0]  lam_q,      lam_d;
    logic        [ORDER_BITS-1:0] step_q,   step_d;
    logic        [FOLD_BITS-1:0] fcnt_q,    fcnt_d;
    logic        [ORDER_BITS-1:0] prime_q,  prime_d;
    logic signed [ACC_W-1:0]    prev_q [ORDER];
    logic signed [ACC_W-1:0]    prev_d [ORDER];
    logic signed [OUT_RES-1:0]  y_q,        y_d;
    logic                       y_valid_q,  y_valid_d;
    logic                       fold_err_q, fold_err_d;
    logic                       overrun_q,  overrun_d;

    // Folding helpers derived from the latched threshold.
    logic signed [ACC_W-1:0]    lam_pos_s;
    logic signed [ACC_W-1:0]    lam_neg_s;
    logic signed [ACC_W-1:0]    lam_two_s;
    logic signed [ACC_W-1:0]    prev_sel_s;
    logic                       above_s;
    logic                       below_s;

    assign lam_pos_s = signed'({{(ACC_W-OUT_RES){1'b0}}, lam_q});
    assign lam_neg_s = -lam_pos_s;
    assign lam_two_s = lam_pos_s + lam_pos_s;
    assign above_s   = (v_q >= lam_pos_s);
    assign below_s   = (v_q <  lam_neg_s);

    // Select the history tap for the current difference step.
    always_comb begin
        prev_sel_s = '0;
        for (int i = 0; i < ORDER; i++) begin
            if (step_q == ORDER_BITS'(i)) begin
                prev_sel_s = prev_q[i];
            end else begin
                prev_sel_s = prev_sel_s;
            end
        end
    end

    // Next-state logic: FSM transitions, datapath updates and sticky flags.
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        lam_d      = lam_q;
        step_d     = step_q;
        fcnt_d     = fcnt_q;
        prime_d    = prime_q;
        prev_d     = prev_q;
        y_d        = y_q;
        y_valid_d  = 1'b0;
        fold_err_d = fold_err_q;
        overrun_d  = overrun_q;

        // A strobe arriving while a sample is in flight is dropped and flagged.
        if (in_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    v_d     = {{(ACC_W-IN_RES){x[IN_RES-1]}}, x};
                    lam_d   = lambda;
                    step_d  = '0;
                    state_d = S_DIFF;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_DIFF: begin
                // prev[d] keeps the pre-subtract value: it is the order-d
                // difference of this sample, needed by the next sample.
                v_d = v_q - prev_sel_s;
                for (int i = 0; i < ORDER; i++) begin
                    if (step_q == ORDER_BITS'(i)) begin
                        prev_d[i] = v_q;
                    end else begin
                        prev_d[i] = prev_q[i];
                    end
                end
                if (step_q == ORDER_BITS'(ORDER - 1)) begin
                    fcnt_d  = '0;
                    state_d = S_FOLD;
                end else begin
                    step_d  = step_q + ORDER_BITS'(1);
                    state_d = S_DIFF;
                end
            end

            S_FOLD: begin
                if ((lam_q == '0) || !(above_s || below_s) ||
                    (fcnt_q == FOLD_BITS'(MAX_FOLD))) begin
                    // Leave the fold: bypassed, in range, or out of steps.
                    if ((lam_q != '0) && (above_s || below_s)) begin
                        fold_err_d = 1'b1;
                    end else begin
                        fold_err_d = fold_err_q;
                    end
                    y_d = v_q[OUT_RES-1:0];
                    if (prime_q == ORDER_BITS'(ORDER)) begin
                        y_valid_d = 1'b1;
                    end else begin
                        prime_d = prime_q + ORDER_BITS'(1);
                    end
                    state_d = S_OUT;
                end else if (above_s) begin
                    v_d    = v_q - lam_two_s;
                    fcnt_d = fcnt_q + FOLD_BITS'(1);
                end else begin
                    v_d    = v_q + lam_two_s;
                    fcnt_d = fcnt_q + FOLD_BITS'(1);
                end
            end

            S_OUT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and flag registers; reset also discards any in-flight sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            v_q        <= '0;
            lam_q      <= '0;
            step_q     <= '0;
            fcnt_q     <= '0;
            prime_q    <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            fold_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                prev_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            lam_q      <= lam_d;
            step_q     <= step_d;
            fcnt_q     <= fcnt_d;
            prime_q    <= prime_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            fold_err_q <= fold_err_d;
            overrun_q  <= overrun_d;
            prev_q     <= prev_d;
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign busy     = (state_q != S_IDLE);
    assign fold_err = fold_err_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_diff_mod_operator.sv
// Directed bench for diff_mod_operator (ORDER=2, MAX_FOLD=4).
// Expected values are hand-computed second differences with centred folding.
module tb_diff_mod_operator;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [11:0] x;
    logic        [15:0] lambda;
    logic signed [15:0] y;
    logic               y_valid;
    logic               busy;
    logic               fold_err;
    logic               overrun;

    int n_assert;
    int n_fail;
    int lat;
    bit seen;
    logic signed [15:0] y_cap;

    diff_mod_operator #(
        .IN_RES(12), .OUT_RES(16), .ORDER(2), .ORDER_BITS(2), .MAX_FOLD(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .lambda(lambda),
        .y(y), .y_valid(y_valid), .busy(busy), .fold_err(fold_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present one sample; optionally hold in_valid one more cycle with xo
    // (lands in DIFF). Records first y_valid latency and y, returns once idle.
    task automatic send(input logic signed [11:0] xi, input logic [15:0] li,
                        input bit pulse, input logic signed [11:0] xo);
        bool_done: begin end
        seen  = 1'b0;
        lat   = -1;
        y_cap = '0;
        @(negedge clk);
        x        = xi;
        lambda   = li;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (pulse) begin
            x        = xo;
            lambda   = 16'd7;
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (y_valid && !seen) begin
                seen  = 1'b1;
                lat   = k;
                y_cap = y;
            end
            if (!busy) break;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        lambda   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_y",        32'(y),        32'd0);
        check("rst_y_valid",  32'(y_valid),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_fold_err", 32'(fold_err), 32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Priming: 0,10,40,90 with lambda=100
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        check("prime1_no_valid", 32'(seen), 32'd0);
        send(12'sd10, 16'd100, 1'b0, 12'sd0);
        check("prime2_no_valid", 32'(seen), 32'd0);
        send(12'sd40, 16'd100, 1'b0, 12'sd0);
        check("prime3_valid", 32'(seen), 32'd1);
        check("prime3_y",     32'(y_cap), 32'd20);
        check("prime3_lat",   lat, 32'd3);
        send(12'sd90, 16'd100, 1'b0, 12'sd0);
        check("prime4_y",     32'(y_cap), 32'd20);
        check("prime4_lat",   lat, 32'd3);
        @(negedge clk);
        check("y_hold_idle",  32'(y), 32'd20);
        check("y_valid_pulse_low", 32'(y_valid), 32'd0);

        // Single fold: 250 -> 50
        do_reset();
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        send(12'sd250, 16'd100, 1'b0, 12'sd0);
        check("fold1_y",   32'(y_cap), 32'd50);
        check("fold1_lat", lat, 32'd4);

        // Multi fold negative: -700 -> -500 -> -300 -> -100
        do_reset();
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        send(-12'sd700, 16'd100, 1'b0, 12'sd0);
        check("fold3_y",        32'(y_cap), -32'sd100);
        check("fold3_lat",      lat, 32'd6);
        check("fold3_fold_err", 32'(fold_err), 32'd0);

        // Fold error: 1900 -> 1100 after 4 steps, flag sticky
        do_reset();
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        send(12'sd1900, 16'd100, 1'b0, 12'sd0);
        check("ferr_y",    32'(y_cap), 32'd1100);
        check("ferr_lat",  lat, 32'd7);
        check("ferr_flag", 32'(fold_err), 32'd1);
        // d1=0, d2=-1900, in range for lambda=2000
        send(12'sd1900, 16'd2000, 1'b0, 12'sd0);
        check("ferr_good1_y",    32'(y_cap), -32'sd1900);
        check("ferr_good1_lat",  lat, 32'd3);
        check("ferr_good1_flag", 32'(fold_err), 32'd1);
        // d1=0, d2=0
        send(12'sd1900, 16'd2000, 1'b0, 12'sd0);
        check("ferr_good2_y",    32'(y_cap), 32'd0);
        check("ferr_good2_flag", 32'(fold_err), 32'd1);

        // Overrun during DIFF and lambda=0 bypass
        do_reset();
        check("ovr_clear_after_reset", 32'(overrun), 32'd0);
        send(12'sd0, 16'd0, 1'b1, 12'sd500);
        check("ovr_flag", 32'(overrun), 32'd1);
        send(12'sd0, 16'd0, 1'b0, 12'sd0);
        send(12'sd300, 16'd0, 1'b0, 12'sd0);
        check("bypass_y",    32'(y_cap), 32'd300);
        check("bypass_lat",  lat, 32'd3);
        check("ovr_sticky",  32'(overrun), 32'd1);

        // Reset mid-FOLD: x=0 gives d2=-600 (3 fold steps); reset at edge 3
        @(negedge clk);
        x        = 12'sd0;
        lambda   = 16'd100;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_fold_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_y",        32'(y),        32'd0);
        check("mrst_y_valid",  32'(y_valid),  32'd0);
        check("mrst_busy",     32'(busy),     32'd0);
        check("mrst_fold_err", 32'(fold_err), 32'd0);
        check("mrst_overrun",  32'(overrun),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("mrst_no_late_valid", 32'(y_valid), 32'd0);
        end
        send(12'sd0, 16'd100, 1'b0, 12'sd0);
        check("reprime1_no_valid", 32'(seen), 32'd0);
        send(12'sd10, 16'd100, 1'b0, 12'sd0);
        check("reprime2_no_valid", 32'(seen), 32'd0);
        send(12'sd40, 16'd100, 1'b0, 12'sd0);
        check("reprime3_y", 32'(y_cap), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
